uart_bram_loader: RTL and testbench
===================================

Name: uart_bram_loader

Overview:
Serial receive stage that feeds the shared dual-port BRAM on port B. It receives 8N1 UART bytes on rx and assembles them big-endian into 16-bit words. It writes a host-specified number of words to consecutive BRAM addresses, starting at a base address. Used by the host sequencer to load the instruction image, then the pixel image, before the processor is released; completion is reported on done, which drives the rx LED.

Parameters:
CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200)
ADDR_W, 16, BRAM address width
CNT_W, 16, width of the word_count input

Ports:
clk  input  1  system clock (25 MHz, the clk1 domain)
rst  input  1  synchronous active-high reset
rx  input  1  UART serial input, asynchronous, idle high
start  input  1  one-cycle pulse; begins a load job
base_addr  input  ADDR_W  first BRAM word address, sampled on start
word_count  input  CNT_W  number of 16-bit words to load, sampled on start
ram_addr  output  ADDR_W  BRAM port-B address
ram_din  output  16  BRAM port-B write data
ram_we  output  1  BRAM port-B write enable, one-cycle strobe
busy  output  1  high while a job is active
done  output  1  high from job completion until the next accepted start or rst
frame_err  output  1  sticky; set on a bad stop bit, cleared on accepted start or rst

Behaviour:
- Reset (sync, rst=1 at a clk edge): all outputs 0 and ram_addr=0; byte/word state cleared; job state IDLE; rx synchroniser loaded with 1s. Reset mid-job aborts it immediately and leaves no pending write.
- rx passes through a 2-flop synchroniser. All bit logic uses the synchronised signal (2-cycle input latency).
- Bit receiver FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE.
  - R_IDLE: a falling edge (sync rx=0) starts the bit counter; go to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles, resample. If still 0, go to R_DATA; otherwise treat it as a glitch and return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT cycles. A 1 gives a valid byte (one-cycle internal byte_valid). A 0 discards the byte, sets frame_err, and the receiver waits for rx=1 before re-entering R_IDLE.
- The receiver runs regardless of job state. Bytes received while not busy are dropped.
- Job FSM: IDLE -> LOAD -> FIN -> IDLE.
  - IDLE: start=1 latches base_addr into ram_addr and word_count into remaining; clears done, frame_err and the byte-phase flag. If word_count==0, go to FIN; else go to LOAD with busy=1.
  - LOAD: the first valid byte of a pair goes to din[15:8]; the second goes to din[7:0].
  - On the second byte: in the next cycle ram_din = assembled word and ram_we=1 for exactly one cycle at the current ram_addr. After that strobe, ram_addr increments (mod 2^ADDR_W, wraps FFFF->0000) and remaining decrements.
  - When remaining reaches 0 after a write, go to FIN.
  - FIN: busy=0, done=1 (held), ram_we=0; return to IDLE.
  - Latency: stop-bit sample of the second byte -> ram_we high in 1 cycle; last write -> done high 1 cycle later.
- start while busy is ignored: no relatch, no clear.
- start in the same cycle as rst: rst wins.
- A byte_valid coinciding with start is dropped, not counted.
- A framing error does not count a byte and does not advance the byte phase. The job continues.
- ram_din holds its last value when ram_we=0.

Test Plan:
- Reset, then start with base=0x0000, count=2, and send bytes 12 34 AB CD -> writes 0x1234@0x0000 and 0xABCD@0x0001, one cycle each. done=1 after the last write and stays 1. busy low after done.
- Start with count=0 -> no ram_we. done=1 two cycles after start.
- Start with base=0xFFFF, count=2, and send 01 02 03 04 -> 0x0102@0xFFFF, then 0x0304@0x0000.
- During a job, send a byte with stop bit 0, then 55 66 -> frame_err=1. The bad byte is discarded and the job writes 0x5566. A new start clears frame_err.
- Bytes sent before start, a second start pulsed mid-job, and a 0.3-bit low glitch on rx -> none cause writes; the original job's address and count are unchanged.
- Assert rst midway through the second byte of a word -> all outputs 0 and no write. A fresh start with count=1 and bytes 9A BC writes 0x9ABC correctly.

Source files
------------

// File: rtl/uart_bram_loader_if.sv
// Job control and BRAM port-B bus of the UART image loader.
// The loader drives the master side; host sequencer and BRAM sit on the slave side.
interface uart_bram_loader_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic              frame_err;

    modport master (
        input  start, base_addr, word_count,
        output ram_addr, ram_din, ram_we, busy, done, frame_err
    );

    modport slave (
        output start, base_addr, word_count,
        input  ram_addr, ram_din, ram_we, busy, done, frame_err
    );
endinterface

// File: rtl/uart_bram_loader.sv
// 8N1 UART receiver that packs big-endian 16-bit words and writes
// a host-sized block of them into BRAM port B.
module uart_bram_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    uart_bram_loader_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
    } rstate_t;

    typedef enum logic [1:0] {
        J_IDLE, J_LOAD, J_FIN
    } jstate_t;

    logic          rx_meta;
    logic          rx_sync;
    rstate_t       rstate;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;
    logic          byte_valid;
    logic          byte_bad;

    jstate_t           jstate;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_din;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [CNT_W-1:0]  remaining;
    logic              phase;
    logic [7:0]        hi;
    logic              accept;

    assign tick       = (cnt == LAST);
    assign byte_valid = (rstate == R_STOP) && tick && rx_sync;
    assign byte_bad   = (rstate == R_STOP) && tick && !rx_sync;
    assign accept     = bus.start && (jstate != J_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rstate  <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            unique case (rstate)
                R_IDLE: begin
                    if (!rx_sync) begin
                        cnt    <= '0;
                        rstate <= R_START;
                    end
                end
                R_START: begin
                    if (cnt == MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (tick) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (tick) begin
                        cnt    <= '0;
                        rstate <= rx_sync ? R_IDLE : R_BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // a low stop bit may be a break; hold off until the line idles
                R_BREAK: begin
                    if (rx_sync) rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jstate    <= J_IDLE;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            remaining <= '0;
            phase     <= 1'b0;
            hi        <= '0;
        end else begin
            ram_we <= 1'b0;
            if (byte_bad) frame_err <= 1'b1;
            if (accept) begin
                ram_addr  <= bus.base_addr;
                remaining <= bus.word_count;
                done      <= 1'b0;
                frame_err <= 1'b0;
                phase     <= 1'b0;
                if (bus.word_count == '0) begin
                    jstate <= J_FIN;
                    busy   <= 1'b0;
                end else begin
                    jstate <= J_LOAD;
                    busy   <= 1'b1;
                end
            end else begin
                unique case (jstate)
                    J_IDLE: jstate <= J_IDLE;
                    J_LOAD: begin
                        if (byte_valid) begin
                            if (!phase) begin
                                hi <= shreg;
                            end else begin
                                ram_din <= {hi, shreg};
                                ram_we  <= 1'b1;
                            end
                            phase <= !phase;
                        end
                        if (ram_we) begin
                            ram_addr  <= ram_addr + ADDR_W'(1);
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                jstate <= J_FIN;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                            end
                        end
                    end
                    J_FIN: begin
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        jstate <= J_IDLE;
                    end
                    default: jstate <= J_IDLE;
                endcase
            end
        end
    end

    assign bus.ram_addr  = ram_addr;
    assign bus.ram_din   = ram_din;
    assign bus.ram_we    = ram_we;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_uart_bram_loader.sv
// Bench for uart_bram_loader: table-driven load jobs plus corner sequences,
// with BRAM writes checked against a queue of expected {addr, data}.
module tb_uart_bram_loader;
    localparam int CPB = 16;

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        logic [31:0] bytes;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #5 clk = ~clk;

    uart_bram_loader_if #(.ADDR_W(16), .CNT_W(16)) bus ();

    uart_bram_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_w;
    logic we_prev = 1'b0;
    logic chk_done_next = 1'b0;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_start(input logic [15:0] base, input logic [15:0] cnt);
        bus.base_addr  = base;
        bus.word_count = cnt;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 4000) begin
            tick(1);
            n++;
        end
        check(name, 32'(bus.done), 32'd1);
    endtask

    // write monitor: one-cycle strobes, in order, and done one cycle after the last
    always @(negedge clk) begin
        if (chk_done_next) begin
            check("done_after_last_write", {30'd0, bus.done, bus.busy}, 32'd2);
            chk_done_next = 1'b0;
        end
        if (bus.ram_we) begin
            check("we_one_cycle", 32'(we_prev), 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h@%h want none",
                         bus.ram_din, bus.ram_addr);
            end else begin
                exp_w = sb.pop_front();
                check("write", {bus.ram_addr, bus.ram_din}, exp_w);
                if (sb.size() == 0) chk_done_next = 1'b1;
            end
        end
        we_prev = bus.ram_we;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0000, 16'd2, 32'h1234ABCD, 32'h0000_0001, 32'h1234_ABCD};
        vecs[1] = '{16'hFFFF, 16'd2, 32'h01020304, 32'hFFFF_0000, 32'h0102_0304};
        vecs[2] = '{16'h1234, 16'd1, 32'h5A0F0000, 32'h1234_0000, 32'h5A0F_0000};

        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        tick(3);
        check("rst_bus", {bus.ram_addr, bus.ram_din}, 32'd0);
        check("rst_flags", {28'd0, bus.ram_we, bus.busy, bus.done, bus.frame_err}, 32'd0);
        rst = 1'b0;
        tick(2);

        for (int v = 0; v < 3; v++) begin
            pulse_start(vecs[v].base, vecs[v].count);
            check("start_busy", 32'(bus.busy), 32'd1);
            for (int w = 0; w < int'(vecs[v].count); w++)
                sb.push_back({vecs[v].exp_addr[16*(1-w) +: 16],
                              vecs[v].exp_data[16*(1-w) +: 16]});
            for (int k = 0; k < 2 * int'(vecs[v].count); k++)
                send_byte(vecs[v].bytes[8*(3-k) +: 8]);
            tick(CPB);
            wait_done("job_done");
            check("end_addr", 32'(bus.ram_addr), 32'(16'(vecs[v].base + vecs[v].count)));
            check("busy_low", 32'(bus.busy), 32'd0);
            check("sb_empty", 32'(sb.size()), 32'd0);
            tick(20);
            check("done_held", 32'(bus.done), 32'd1);
        end

        // framing error mid-job: byte discarded, job carries on
        pulse_start(16'h0600, 16'd1);
        sb.push_back(32'h0600_5566);
        send_byte(8'hA5, 1'b0);
        tick(2 * CPB);
        check("ferr_set", {30'd0, bus.frame_err, bus.busy}, 32'd3);
        send_byte(8'h55);
        send_byte(8'h66);
        tick(CPB);
        wait_done("ferr_job_done");
        check("ferr_sticky", 32'(bus.frame_err), 32'd1);

        // zero-length job
        bus.base_addr = 16'h0700;
        bus.word_count = 16'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("zero_c1", {30'd0, bus.done, bus.busy}, 32'd0);
        check("zero_ferr_clr", 32'(bus.frame_err), 32'd0);
        tick(1);
        check("zero_c2", {30'd0, bus.done, bus.busy}, 32'd2);
        tick(20);
        check("zero_addr", 32'(bus.ram_addr), 32'h0700);

        // stray bytes, restart mid-job and a short glitch are all ignored
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start(16'h0200, 16'd2);
        sb.push_back(32'h0200_1122);
        sb.push_back(32'h0201_3344);
        send_byte(8'h11);
        pulse_start(16'h0300, 16'd5);
        check("mid_start_busy", 32'(bus.busy), 32'd1);
        check("mid_start_addr", 32'(bus.ram_addr), 32'h0200);
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(2 * CPB);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        tick(CPB);
        wait_done("ignore_job_done");
        check("ignore_end_addr", 32'(bus.ram_addr), 32'h0202);

        // reset in the middle of the second byte of a word
        pulse_start(16'h0400, 16'd1);
        send_byte(8'h77);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(3 * CPB);
        rst = 1'b1;
        tick(1);
        check("midrst_bus", {bus.ram_addr, bus.ram_din}, 32'd0);
        check("midrst_flags", {28'd0, bus.ram_we, bus.busy, bus.done, bus.frame_err}, 32'd0);
        rst = 1'b0;
        tick(12 * CPB);

        bus.base_addr = 16'h0800;
        bus.word_count = 16'd1;
        bus.start = 1'b1;
        rst = 1'b1;
        tick(1);
        bus.start = 1'b0;
        rst = 1'b0;
        tick(2);
        check("rst_beats_start", {30'd0, bus.done, bus.busy}, 32'd0);

        pulse_start(16'h0500, 16'd1);
        sb.push_back(32'h0500_9ABC);
        send_byte(8'h9A);
        send_byte(8'hBC);
        tick(CPB);
        wait_done("post_rst_done");
        check("post_rst_sb", 32'(sb.size()), 32'd0);
        check("post_rst_addr", 32'(bus.ram_addr), 32'h0501);

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
